// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between a fetch and a load/store requester.
// Ports: clk/resetn (async active-low); i_* fetch requester (req/addr in, gnt/rvalid/rdata out);
// d_* data requester (req/we/addr/be/wdata in, gnt/rvalid/rdata out); mem_* single memory port
// (req/we/addr/be/wdata out, gnt/rvalid/rdata in); f_wait_o/m_wait_o stall indicators.
module mem_port_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_req_i,
    input  logic [31:0] i_addr_i,
    output logic        i_gnt_o,
    output logic        i_rvalid_o,
    output logic [31:0] i_rdata_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [31:0] d_addr_i,
    input  logic [3:0]  d_be_i,
    input  logic [31:0] d_wdata_i,
    output logic        d_gnt_o,
    output logic        d_rvalid_o,
    output logic [31:0] d_rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        f_wait_o,
    output logic        m_wait_o
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
    state_t     state_q, state_d;
    logic [2:0] starve_q, starve_d;
    logic       we_q, we_d;
    logic       sel_i, req, gnt, rsp_i, rsp_d;
    // Outputs are gated by resetn so they drop to zero the moment reset asserts, not at the next edge.
    assign sel_i = i_req_i & (~d_req_i | (int'(starve_q) == STARVE_MAX));
    assign req   = resetn & (state_q == IDLE) & (i_req_i | d_req_i);
    assign gnt   = req & mem_gnt_i;
    assign rsp_i = resetn & (state_q == BUSY_I) & mem_rvalid_i;
    assign rsp_d = resetn & (state_q == BUSY_D) & mem_rvalid_i;
    assign mem_req_o   = req;
    assign mem_we_o    = req & ~sel_i & d_we_i;
    assign mem_addr_o  = req ? (sel_i ? i_addr_i : d_addr_i) : '0;
    assign mem_be_o    = req ? (sel_i ? 4'hF : d_be_i) : '0;
    assign mem_wdata_o = (req & ~sel_i) ? d_wdata_i : '0;
    assign i_gnt_o     = gnt & sel_i;
    assign d_gnt_o     = gnt & ~sel_i;
    assign i_rvalid_o  = rsp_i;
    assign i_rdata_o   = rsp_i ? mem_rdata_i : '0;
    assign d_rvalid_o  = rsp_d;
    // Stores are acknowledged with zero data; the transaction type is remembered in we_q.
    assign d_rdata_o   = (rsp_d & ~we_q) ? mem_rdata_i : '0;
    assign f_wait_o    = resetn & i_req_i & ~rsp_i;
    assign m_wait_o    = resetn & (d_req_i | (state_q == BUSY_D)) & ~rsp_d;
    always_comb begin
        state_d  = gnt ? (sel_i ? BUSY_I : BUSY_D) : (rsp_i | rsp_d) ? IDLE : state_q;
        we_d     = gnt ? (~sel_i & d_we_i) : we_q;
        starve_d = (~i_req_i | i_gnt_o) ? 3'd0 : (d_gnt_o && starve_q != 3'd7) ? starve_q + 3'd1 : starve_q;
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            starve_q <= '0;
            we_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            we_q     <= we_d;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a queue-based reference model checked every cycle.
module tb_mem_port_arbiter;
    localparam int STARVE_MAX = 4;
    logic        clk = 1'b0, resetn = 1'b0;
    logic        i_req_i = 0, d_req_i = 0, d_we_i = 0, mem_gnt_i = 0, mem_rvalid_i = 0;
    logic [31:0] i_addr_i = 0, d_addr_i = 0, d_wdata_i = 0, mem_rdata_i = 0;
    logic [3:0]  d_be_i = 0;
    logic        i_gnt_o, i_rvalid_o, d_gnt_o, d_rvalid_o, mem_req_o, mem_we_o, f_wait_o, m_wait_o;
    logic [31:0] i_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    int n_chk = 0, n_fail = 0;

    mem_port_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .resetn(resetn),
        .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_gnt_o(i_gnt_o), .i_rvalid_o(i_rvalid_o), .i_rdata_o(i_rdata_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_be_i(d_be_i), .d_wdata_i(d_wdata_i),
        .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
        .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .f_wait_o(f_wait_o), .m_wait_o(m_wait_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Reference model: transactions in flight (1 fetch, 2 load, 3 store) and a starvation count.
    int pend[$];
    int starve = 0;

    typedef struct packed {
        logic        i_gnt, i_rvalid;
        logic [31:0] i_rdata;
        logic        d_gnt, d_rvalid;
        logic [31:0] d_rdata;
        logic        mreq, mwe;
        logic [31:0] maddr;
        logic [3:0]  mbe;
        logic [31:0] mwdata;
        logic        fw, mw, data_sel;
    } exp_t;

    function automatic exp_t model();
        exp_t e = '0;
        bit   fetch_wins;
        if (!resetn) return e;
        if (pend.size() == 0 && (i_req_i || d_req_i)) begin
            fetch_wins = i_req_i && (!d_req_i || starve == STARVE_MAX);
            e.mreq     = 1'b1;
            e.data_sel = !fetch_wins;
            e.mwe      = fetch_wins ? 1'b0 : d_we_i;
            e.maddr    = fetch_wins ? i_addr_i : d_addr_i;
            e.mbe      = fetch_wins ? 4'hF : d_be_i;
            e.mwdata   = d_wdata_i;
            e.i_gnt    = fetch_wins && mem_gnt_i;
            e.d_gnt    = !fetch_wins && mem_gnt_i;
        end
        if (pend.size() != 0 && mem_rvalid_i) begin
            if (pend[0] == 1) begin
                e.i_rvalid = 1'b1;
                e.i_rdata  = mem_rdata_i;
            end else begin
                e.d_rvalid = 1'b1;
                e.d_rdata  = (pend[0] == 2) ? mem_rdata_i : 32'h0;
            end
        end
        e.fw = i_req_i && !e.i_rvalid;
        e.mw = (d_req_i || (pend.size() != 0 && pend[0] != 1)) && !e.d_rvalid;
        return e;
    endfunction

    always @(posedge clk or negedge resetn) begin
        exp_t e;
        if (!resetn) begin
            pend.delete();
            starve <= 0;
        end else begin
            e = model();
            if (e.i_rvalid || e.d_rvalid) void'(pend.pop_front());
            if (e.i_gnt) pend.push_back(1);
            if (e.d_gnt) pend.push_back(d_we_i ? 3 : 2);
            starve <= (!i_req_i || e.i_gnt) ? 0 : (e.d_gnt && starve < 7) ? starve + 1 : starve;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        e = model();
        chk("i_gnt", 32'(i_gnt_o), 32'(e.i_gnt));
        chk("d_gnt", 32'(d_gnt_o), 32'(e.d_gnt));
        chk("i_rvalid", 32'(i_rvalid_o), 32'(e.i_rvalid));
        chk("i_rdata", i_rdata_o, e.i_rdata);
        chk("d_rvalid", 32'(d_rvalid_o), 32'(e.d_rvalid));
        chk("d_rdata", d_rdata_o, e.d_rdata);
        chk("mem_req", 32'(mem_req_o), 32'(e.mreq));
        chk("f_wait", 32'(f_wait_o), 32'(e.fw));
        chk("m_wait", 32'(m_wait_o), 32'(e.mw));
        if (e.mreq || !resetn) begin
            chk("mem_we", 32'(mem_we_o), 32'(e.mwe));
            chk("mem_addr", mem_addr_o, e.maddr);
            chk("mem_be", 32'(mem_be_o), 32'(e.mbe));
        end
        if (e.data_sel || !resetn) chk("mem_wdata", mem_wdata_o, e.mwdata);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        int k;
        logic [5:0] seq;
        // Reset: outputs forced low even with a request pending.
        i_req_i = 1; i_addr_i = 32'h100;
        mid();
        chk("rst_mem_req", 32'(mem_req_o), 0);
        chk("rst_f_wait", 32'(f_wait_o), 0);
        chk("rst_mem_be", 32'(mem_be_o), 0);
        step();
        i_req_i = 0;
        step();
        resetn = 1;
        step();
        // Fetch only, response two cycles after the grant.
        i_req_i = 1; i_addr_i = 32'h100; mem_gnt_i = 1;
        mid();
        chk("f_gnt", 32'(i_gnt_o), 1);
        chk("f_addr", mem_addr_o, 32'h100);
        chk("f_be", 32'(mem_be_o), 32'hF);
        chk("f_we", 32'(mem_we_o), 0);
        step();
        i_req_i = 0; mem_gnt_i = 0;
        mid();
        chk("f_busy_req", 32'(mem_req_o), 0);
        step();
        mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF;
        mid();
        chk("f_rvalid", 32'(i_rvalid_o), 1);
        chk("f_rdata", i_rdata_o, 32'hDEADBEEF);
        step();
        // Stray response while idle is ignored.
        mid();
        chk("idle_rvalid", 32'(i_rvalid_o), 0);
        step();
        mem_rvalid_i = 0; mem_rdata_i = 0;
        step();
        // Simultaneous fetch and store: store first, fetch after the store ack.
        i_req_i = 1; i_addr_i = 32'h300;
        d_req_i = 1; d_we_i = 1; d_addr_i = 32'h2000; d_be_i = 4'b0011; d_wdata_i = 32'h12345678;
        mem_gnt_i = 1;
        mid();
        chk("s_dgnt", 32'(d_gnt_o), 1);
        chk("s_ignt", 32'(i_gnt_o), 0);
        chk("s_we", 32'(mem_we_o), 1);
        chk("s_be", 32'(mem_be_o), 32'h3);
        chk("s_addr", mem_addr_o, 32'h2000);
        step();
        d_req_i = 0;
        step();
        mem_rvalid_i = 1; mem_rdata_i = 32'hAAAA5555;
        mid();
        chk("s_ack", 32'(d_rvalid_o), 1);
        chk("s_ack_data", d_rdata_o, 0);
        chk("s_no_b2b", 32'(i_gnt_o), 0);
        step();
        mem_rvalid_i = 0;
        mid();
        chk("s_fetch_gnt", 32'(i_gnt_o), 1);
        chk("s_fetch_addr", mem_addr_o, 32'h300);
        step();
        i_req_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h0BADF00D;
        step();
        mem_rvalid_i = 0; mem_gnt_i = 0;
        step();
        // Starvation limit: four data grants then one fetch grant.
        i_req_i = 1; i_addr_i = 32'h400;
        d_req_i = 1; d_we_i = 0; d_addr_i = 32'h500; d_be_i = 4'hF;
        mem_gnt_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'hCAFEF00D;
        k = 0; seq = '0;
        for (int c = 0; c < 40 && k < 6; c++) begin
            mid();
            if (i_gnt_o || d_gnt_o) begin
                seq[k] = i_gnt_o;
                k++;
            end
            step();
        end
        chk("starve_grants", 32'(k), 6);
        chk("starve_order", 32'(seq), 32'b010000);
        i_req_i = 0; d_req_i = 0; mem_gnt_i = 0;
        step();
        mem_rvalid_i = 0;
        step();
        // Memory stalls grant for five cycles.
        i_req_i = 1; i_addr_i = 32'h600;
        d_req_i = 1; d_we_i = 0; d_addr_i = 32'h700;
        for (int c = 0; c < 5; c++) begin
            mid();
            chk("stall_req", 32'(mem_req_o), 1);
            chk("stall_addr", mem_addr_o, 32'h700);
            chk("stall_fw", 32'(f_wait_o), 1);
            chk("stall_mw", 32'(m_wait_o), 1);
            step();
        end
        mem_gnt_i = 1;
        mid();
        chk("stall_dgnt", 32'(d_gnt_o), 1);
        step();
        i_req_i = 0; d_req_i = 0; mem_gnt_i = 0;
        mid();
        chk("busy_d_mw", 32'(m_wait_o), 1);
        step();
        // Reset while a load is outstanding, then a late response.
        resetn = 0;
        #1;
        chk("midrst_mw", 32'(m_wait_o), 0);
        chk("midrst_be", 32'(mem_be_o), 0);
        step();
        resetn = 1; mem_rvalid_i = 1; mem_rdata_i = 32'h55;
        mid();
        chk("late_rvalid", 32'(d_rvalid_o), 0);
        chk("late_rdata", d_rdata_o, 0);
        step();
        mem_rvalid_i = 0;
        // Withdrawn request before grant.
        d_req_i = 1; d_addr_i = 32'h800;
        mid();
        chk("wd_req", 32'(mem_req_o), 1);
        step();
        d_req_i = 0;
        mid();
        chk("wd_gone", 32'(mem_req_o), 0);
        step();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, meaning consecutive data grants allowed while a fetch waits.
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
  clk  input  1  single clock, all state on rising edge
  resetn  input  1  asynchronous active-low reset
  i_req_i  input  1  fetch request, held until i_gnt_o
  i_addr_i  input  32  fetch word address
  i_gnt_o  output  1  fetch request accepted this cycle
  i_rvalid_o  output  1  fetch data valid, one-cycle pulse
  i_rdata_o  output  32  fetch read data
  d_req_i  input  1  load/store request, held until d_gnt_o
  d_we_i  input  1  1 = store, 0 = load
  d_addr_i  input  32  data address
  d_be_i  input  4  store byte enables
  d_wdata_i  input  32  store data
  d_gnt_o  output  1  data request accepted this cycle
  d_rvalid_o  output  1  load data or store ack, one-cycle pulse
  d_rdata_o  output  32  load read data
  mem_req_o  output  1  memory port request
  mem_we_o  output  1  memory write enable
  mem_addr_o  output  32  memory address
  mem_be_o  output  4  memory byte enables
  mem_wdata_o  output  32  memory write data
  mem_gnt_i  input  1  memory accepted request
  mem_rvalid_i  input  1  memory response (read data or write ack)
  mem_rdata_i  input  32  memory read data
  f_wait_o  output  1  fetch stalled (i_req_i high, no i_rvalid_o this cycle)
  m_wait_o  output  1  data stalled (d_req_i high or data outstanding, no d_rvalid_o)

Function
REQ-003 SHALL implement FSM states IDLE, BUSY_I, BUSY_D; at most one transaction outstanding.
REQ-004 SHALL, in IDLE, assert mem_req_o combinationally when i_req_i or d_req_i is high, driving the selected requester's address/we/be/wdata.
REQ-005 SHALL select data over fetch, except when starve_cnt equals STARVE_MAX and i_req_i is high, then fetch wins.
REQ-006 SHALL drive mem_we_o=0 and mem_be_o=4'hF for fetch requests.
REQ-007 SHALL assert i_gnt_o/d_gnt_o the same cycle as mem_gnt_i with mem_req_o high, for the selected requester only; never both.
REQ-008 SHALL move IDLE->BUSY_I or IDLE->BUSY_D on a granted request; stay IDLE otherwise.
REQ-009 SHALL hold mem_req_o low in BUSY_I/BUSY_D.
REQ-010 SHALL, on mem_rvalid_i in BUSY_I, pulse i_rvalid_o with i_rdata_o=mem_rdata_i, return to IDLE.
REQ-011 SHALL, on mem_rvalid_i in BUSY_D, pulse d_rvalid_o with d_rdata_o=mem_rdata_i (loads) or 0 (stores), return to IDLE.
REQ-012 SHALL ignore mem_rvalid_i in IDLE (no rvalid pulse, no state change).
REQ-013 SHALL, after a response, accept a new request no earlier than the following cycle (no back-to-back in the response cycle).
REQ-014 SHALL increment 3-bit saturating starve_cnt on each data grant while i_req_i is high; clear on any fetch grant or when i_req_i is low.
REQ-015 SHALL keep rdata outputs at 0 when corresponding rvalid is low.
REQ-016 SHALL treat a requester dropping its req before grant as withdrawn, with no error.

Reset
REQ-017 SHALL, on resetn low, immediately force state IDLE, starve_cnt 0, all outputs 0 (mem_be_o 0) regardless of clk.
REQ-018 SHALL discard any outstanding transaction on reset mid-operation; a late mem_rvalid_i after reset produces no rvalid pulse.

Verification
REQ-019 Fetch only: i_req_i=1, addr 0x100, mem_gnt_i same cycle, mem_rvalid_i 2 cycles later with 0xDEADBEEF -> i_gnt_o 1 cycle, i_rvalid_o pulse with 0xDEADBEEF.
REQ-020 Simultaneous i_req_i and d_req_i (store, addr 0x2000, be 4'b0011) -> d_gnt_o first, mem_we_o=1, mem_be_o=4'b0011; fetch granted after d_rvalid_o.
REQ-021 Continuous d_req_i with i_req_i high, STARVE_MAX=4 -> 4 data grants, then 1 fetch grant, then data again.
REQ-022 mem_gnt_i held low 5 cycles -> mem_req_o and address stable, f_wait_o/m_wait_o high throughout.
REQ-023 resetn low while BUSY_D, then mem_rvalid_i=1 after release -> no d_rvalid_o, state IDLE, outputs 0.
